// File: rtl/processador_pkg.sv
// Shared definitions for the multicycle processor and its instruction feeder:
// opcodes, the IR opcode field and the feeder state encoding.
package processador_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_F0    = 4'd1,
        S_F1    = 4'd2,
        S_F2    = 4'd3,
        S_ISSUE = 4'd4,
        S_EXEC  = 4'd5,
        S_WAIT  = 4'd6,
        S_NEXT  = 4'd7,
        S_HALT  = 4'd8,
        S_ERR   = 4'd9
    } state_e;

    function automatic logic [2:0] opcode(input logic [8:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/feeder_watchdog.sv
// Counts cycles spent waiting for Done; tc marks the last allowed wait cycle.
module feeder_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_feeder.sv
// Fetches one or two ROM words per instruction, pulses Run, then waits for
// Done before advancing pc; stops at program end or on a Done timeout.
module instruction_feeder
    import processador_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int PROG_LEN = 32,
    parameter int TIMEOUT  = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Done,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] pc,
    output logic              Busy,
    output logic              Halted,
    output logic              Err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN      = (ADDR_W + 1)'(PROG_LEN);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] w0_q, w0_d;
    logic [DATA_W-1:0] w1_q, w1_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;

    logic            wd_clr, wd_en, wd_tc;
    logic            is_mvi;
    logic [ADDR_W:0] npc;

    // Extra bit on npc so running past the last ROM word is seen, not wrapped
    assign is_mvi = (opcode(w0_q[8:0]) == OP_MVI);
    assign npc    = {1'b0, pc_q}
                  + {{(ADDR_W-1){1'b0}}, is_mvi, ~is_mvi};

    feeder_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk  (Clock),
        .rst_n(Resetn),
        .clr  (wd_clr),
        .en   (wd_en),
        .tc   (wd_tc)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        w0_d     = w0_q;
        w1_d     = w1_q;
        halted_d = halted_q;
        err_d    = err_q;
        mem_addr = pc_q;
        DIN      = '0;
        Run      = 1'b0;
        wd_clr   = 1'b0;
        wd_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_F0;
            end
            S_F0: begin
                state_d = S_F1;
            end
            S_F1: begin
                mem_addr = pc_q + ADDR_ONE;
                w0_d     = mem_data;
                state_d  = S_F2;
            end
            S_F2: begin
                w1_d    = mem_data;
                wd_clr  = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                DIN     = w0_q;
                Run     = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                DIN     = is_mvi ? w1_q : w0_q;
                state_d = Done ? S_NEXT : S_WAIT;
            end
            S_WAIT: begin
                DIN   = is_mvi ? w1_q : w0_q;
                wd_en = 1'b1;
                if (Done) begin
                    state_d = S_NEXT;
                end else if (wd_tc) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_NEXT: begin
                if (npc >= LEN) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d    = npc[ADDR_W-1:0];
                    state_d = Start ? S_F0 : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign pc     = pc_q;
    assign Halted = halted_q;
    assign Err    = err_q;
    assign Busy   = !(state_q inside {S_IDLE, S_HALT, S_ERR});

endmodule

// File: tb/tb_instruction_feeder.sv
// Drives random and directed programs through instruction_feeder and checks
// Run/DIN/pc against a transaction-level model of the fetch-issue loop.
module tb_instruction_feeder;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int PL = 32;

    logic          Clock  = 1'b0;
    logic          Resetn = 1'b0;
    logic          Start  = 1'b0;
    logic          Done   = 1'b0;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] DIN;
    logic          Run;
    logic [AW-1:0] pc;
    logic          Busy;
    logic          Halted;
    logic          Err;

    logic [DW-1:0] rom [0:PL-1];

    int n_pass  = 0;
    int n_total = 0;
    int mpc     = 0;

    always #5 Clock = ~Clock;

    always @(posedge Clock) mem_data <= rom[mem_addr];

    instruction_feeder dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Start   (Start),
        .Done    (Done),
        .mem_data(mem_data),
        .mem_addr(mem_addr),
        .DIN     (DIN),
        .Run     (Run),
        .pc      (pc),
        .Busy    (Busy),
        .Halted  (Halted),
        .Err     (Err)
    );

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] plain_word();
        logic [DW-1:0] w;
        logic [2:0]    op;
        w = DW'($urandom);
        op = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'(1 + $urandom_range(1, 2));
        w[8:6] = op;
        return w;
    endfunction

    task automatic do_reset();
        Resetn = 1'b0;
        Start  = 1'b0;
        Done   = 1'b0;
        tick();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_din", 32'(DIN), 0);
        chk("rst_run", 32'(Run), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_halted", 32'(Halted), 0);
        chk("rst_err", 32'(Err), 0);
        Resetn = 1'b1;
        mpc = 0;
    endtask

    task automatic wait_run(input int exp_gap);
        int n = 0;
        do begin
            tick();
            n++;
        end while (Run !== 1'b1 && n < 40);
        chk("run_gap", n, exp_gap);
    endtask

    // Called at the ISSUE cycle; returns at the cycle after NEXT
    task automatic do_instr(input int d, input bit drop, output bit halted);
        logic [DW-1:0] w0, w1;
        bit            mvi;
        int            npc;
        w0  = rom[mpc];
        mvi = (w0[8:6] == 3'b001);
        w1  = mvi ? rom[(mpc + 1) % PL] : w0;
        chk("din_issue", 32'(DIN), 32'(w0));
        chk("pc_issue", 32'(pc), mpc);
        chk("busy_issue", 32'(Busy), 1);
        Done = 1'($urandom_range(0, 1));
        tick();
        Done = 1'b0;
        chk("din_exec", 32'(DIN), 32'(w1));
        chk("run_once", 32'(Run), 0);
        for (int k = 1; k < d; k++) tick();
        chk("din_hold", 32'(DIN), 32'(w1));
        if (drop) Start = 1'b0;
        Done = 1'b1;
        tick();
        Done = 1'b0;
        npc    = mpc + (mvi ? 2 : 1);
        halted = (npc >= PL);
        if (!halted) mpc = npc;
        tick();
        if (halted) begin
            chk("halt_flag", 32'(Halted), 1);
            chk("halt_busy", 32'(Busy), 0);
            chk("halt_run", 32'(Run), 0);
        end else begin
            chk("pc_next", 32'(pc), mpc);
            chk("busy_next", 32'(Busy), 32'(Start));
        end
    endtask

    task automatic run_prog(input int first_d);
        bit h = 1'b0;
        int d;
        do_reset();
        Start = 1'b1;
        wait_run(4);
        for (int i = 0; i < 40 && !h; i++) begin
            d = (i == 0) ? first_d : $urandom_range(1, 16);
            do_instr(d, 1'b0, h);
            if (!h) wait_run(3);
        end
        chk("prog_halted", 32'(h), 1);
        for (int i = 0; i < 6; i++) begin
            Start = ~Start;
            tick();
            chk("halt_no_run", 32'(Run), 0);
            chk("halt_sticky", 32'(Halted), 1);
        end
        Start = 1'b0;
    endtask

    initial begin
        bit h;

        // Directed program: mv at 0, mvi at 3, mvi at last address
        for (int i = 0; i < PL; i++) rom[i] = plain_word();
        rom[0]  = 16'h0001;
        rom[3]  = 16'h0050;
        rom[4]  = 16'h0005;
        rom[31] = 16'hA040;
        run_prog(2);

        // Random programs
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < PL; i++) begin
                rom[i] = DW'($urandom);
                rom[i][8:6] = 3'($urandom_range(0, 3));
            end
            run_prog($urandom_range(1, 16));
        end

        // Done withheld: watchdog trap
        for (int i = 0; i < PL; i++) rom[i] = plain_word();
        rom[0] = 16'h0081;
        do_reset();
        Start = 1'b1;
        wait_run(4);
        for (int t = 1; t <= 20; t++) begin
            tick();
            chk("to_no_run", 32'(Run), 0);
            if (t == 16) chk("to_err_early", 32'(Err), 0);
            if (t == 17) begin
                chk("to_err", 32'(Err), 1);
                chk("to_busy", 32'(Busy), 0);
            end
        end
        chk("to_err_sticky", 32'(Err), 1);

        // Reset in the middle of WAIT
        rom[0] = 16'h0001;
        rom[1] = 16'h0081;
        do_reset();
        Start = 1'b1;
        wait_run(4);
        do_instr(1, 1'b0, h);
        wait_run(3);
        chk("mid_pc", 32'(pc), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_busy", 32'(Busy), 1);
        do_reset();
        Start = 1'b1;
        wait_run(4);
        chk("restart_pc", 32'(pc), 0);

        // Start dropped during WAIT
        do_reset();
        Start = 1'b1;
        wait_run(4);
        do_instr(5, 1'b1, h);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drop_no_run", 32'(Run), 0);
        end
        chk("drop_idle", 32'(Busy), 0);
        chk("drop_pc", 32'(pc), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
